// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle instruction control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Fetches an instruction word, registers its decode fields, resolves branches,
// sequences a single load/store handshake with a timeout, and commits in WB.
//
// Optional build macro: CTRL_ILLEGAL_TRAP_EN
//   defined   -> unlisted opcodes set illegal and halt after EXEC
//   undefined -> unlisted opcodes retire as NOPs, illegal stays 0
//
// Ports:
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   ifu_req / ifu_ack / inst   instruction fetch handshake and instruction word
//   rs1_val / rs2_val          register operands for the latched instruction
//   lsu_req / lsu_we / lsu_ack memory access handshake
//   alu_src .. word_op         registered decode fields
//   reg_w / pc_we              one-cycle commit strobes in WB
//   busy / halted / illegal / mem_err / instret   status
module mc_ctrl #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ifu_req,
  input  logic             ifu_ack,
  input  logic [31:0]      inst,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  output logic             lsu_req,
  output logic             lsu_we,
  input  logic             lsu_ack,
  output logic             alu_src,
  output logic             mem2reg,
  output logic             spc2reg,
  output logic             mem_r,
  output logic             mem_w,
  output logic [1:0]       alu_op,
  output logic [1:0]       has_funct,
  output logic             jump,
  output logic             pc2imm,
  output logic             word_op,
  output logic             reg_w,
  output logic             pc_we,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  // Decode bundle; wr_rd is internal and qualifies reg_w in WB.
  typedef struct packed {
    logic       alu_src;
    logic       mem2reg;
    logic       spc2reg;
    logic       mem_r;
    logic       mem_w;
    logic [1:0] alu_op;
    logic [1:0] has_funct;
    logic       jump;
    logic       pc2imm;
    logic       word_op;
    logic       wr_rd;
  } dec_t;

  logic [2:0]        state_q,   state_d;
  logic [31:0]       ir_q,      ir_d;
  dec_t              dec_q,     dec_d;
  logic [WAIT_W-1:0] wait_q,    wait_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              ifu_req_q, ifu_req_d;
  logic              lsu_req_q, lsu_req_d;
  logic              lsu_we_q,  lsu_we_d;
  logic              reg_w_q,   reg_w_d;
  logic              pc_we_q,   pc_we_d;
  logic              busy_q,    busy_d;
  logic              halted_q,  halted_d;
  logic              illegal_q, illegal_d;
  logic              mem_err_q, mem_err_d;

  dec_t              dec_c;
  logic              known_c;
  logic              br_taken_c;

  // Opcode to decode fields.
  always_comb begin
    dec_c   = '0;
    known_c = 1'b1;
    case (ir_q[6:0])
      OP_LOAD:   begin dec_c.alu_src = 1'b1; dec_c.mem2reg = 1'b1; dec_c.mem_r = 1'b1; dec_c.wr_rd = 1'b1; end
      OP_STORE:  begin dec_c.alu_src = 1'b1; dec_c.mem_w = 1'b1; end
      OP_IMM:    begin dec_c.alu_src = 1'b1; dec_c.has_funct = 2'b01; dec_c.wr_rd = 1'b1; end
      OP_REG:    begin dec_c.alu_op = 2'b10; dec_c.has_funct = 2'b11; dec_c.wr_rd = 1'b1; end
      OP_AUIPC:  begin dec_c.alu_src = 1'b1; dec_c.pc2imm = 1'b1; dec_c.wr_rd = 1'b1; end
      OP_JAL:    begin dec_c.spc2reg = 1'b1; dec_c.jump = 1'b1; dec_c.pc2imm = 1'b1; dec_c.wr_rd = 1'b1; end
      OP_JALR:   begin dec_c.spc2reg = 1'b1; dec_c.jump = 1'b1; dec_c.alu_src = 1'b1; dec_c.wr_rd = 1'b1; end
      OP_REG32:  begin dec_c.alu_op = 2'b10; dec_c.has_funct = 2'b11; dec_c.word_op = 1'b1; dec_c.wr_rd = 1'b1; end
      OP_IMM32:  begin dec_c.alu_src = 1'b1; dec_c.has_funct = 2'b01; dec_c.word_op = 1'b1; dec_c.wr_rd = 1'b1; end
      OP_BRANCH: begin dec_c.alu_op = 2'b01; end
      OP_SYSTEM: begin dec_c = '0; end
      default:   begin known_c = 1'b0; end
    endcase
  end

  // Full-width branch compare on funct3.
  always_comb begin
    br_taken_c = 1'b0;
    case (ir_q[14:12])
      3'b000:  br_taken_c = (rs1_val == rs2_val);
      3'b001:  br_taken_c = (rs1_val != rs2_val);
      3'b100:  br_taken_c = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken_c = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken_c = (rs1_val <  rs2_val);
      3'b111:  br_taken_c = (rs1_val >= rs2_val);
      default: br_taken_c = 1'b0;
    endcase
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    dec_d     = dec_q;
    wait_d    = wait_q;
    instret_d = instret_q;
    illegal_d = illegal_q;
    mem_err_d = mem_err_q;

    case (state_q)
      S_FETCH: begin
        if (ifu_ack) begin
          ir_d    = inst;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        dec_d   = dec_c;
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (!known_c) illegal_d = 1'b1;
`endif
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (ir_q[6:0] == OP_BRANCH) dec_d.jump = br_taken_c;
        if (illegal_q || ir_q == EBREAK) begin
          state_d = S_HALT;
        end else if (dec_q.mem_r || dec_q.mem_w) begin
          wait_d  = '0;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // An ack on the final allowed cycle still commits.
        if (lsu_ack) begin
          state_d = S_WB;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          mem_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    if (state_d == S_FETCH || state_d == S_HALT) dec_d = '0;

    ifu_req_d = (state_d == S_FETCH);
    lsu_req_d = (state_d == S_MEM);
    lsu_we_d  = (state_d == S_MEM) && dec_d.mem_w;
    pc_we_d   = (state_d == S_WB);
    reg_w_d   = (state_d == S_WB) && dec_d.wr_rd;
    halted_d  = (state_d == S_HALT);
    busy_d    = (state_d != S_HALT);
    if (state_d == S_WB) instret_d = instret_q + CNT_W'(1);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      dec_q     <= '0;
      wait_q    <= '0;
      instret_q <= '0;
      ifu_req_q <= 1'b1;
      lsu_req_q <= 1'b0;
      lsu_we_q  <= 1'b0;
      reg_w_q   <= 1'b0;
      pc_we_q   <= 1'b0;
      busy_q    <= 1'b1;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      dec_q     <= dec_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      ifu_req_q <= ifu_req_d;
      lsu_req_q <= lsu_req_d;
      lsu_we_q  <= lsu_we_d;
      reg_w_q   <= reg_w_d;
      pc_we_q   <= pc_we_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign ifu_req   = ifu_req_q;
  assign lsu_req   = lsu_req_q;
  assign lsu_we    = lsu_we_q;
  assign alu_src   = dec_q.alu_src;
  assign mem2reg   = dec_q.mem2reg;
  assign spc2reg   = dec_q.spc2reg;
  assign mem_r     = dec_q.mem_r;
  assign mem_w     = dec_q.mem_w;
  assign alu_op    = dec_q.alu_op;
  assign has_funct = dec_q.has_funct;
  assign jump      = dec_q.jump;
  assign pc2imm    = dec_q.pc2imm;
  assign word_op   = dec_q.word_op;
  assign reg_w     = reg_w_q;
  assign pc_we     = pc_we_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign mem_err   = mem_err_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl (MEM_TIMEOUT=4).
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req, ifu_ack;
  logic [31:0] inst;
  logic [63:0] rs1_val, rs2_val;
  logic        lsu_req, lsu_we, lsu_ack;
  logic        alu_src, mem2reg, spc2reg, mem_r, mem_w;
  logic [1:0]  alu_op, has_funct;
  logic        jump, pc2imm, word_op;
  logic        reg_w, pc_we, busy, halted, illegal, mem_err;
  logic [31:0] instret;

  int n_checks = 0;
  int n_errors = 0;

  // Results of the last issued instruction.
  int   r_lat, r_lsu, r_regw, r_pcwe;
  logic r_we, r_done;
  logic cap_alu_src, cap_mem2reg, cap_jump;
  logic [1:0] cap_alu_op;

  mc_ctrl #(.XLEN(64), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req(ifu_req), .ifu_ack(ifu_ack), .inst(inst),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_ack(lsu_ack),
    .alu_src(alu_src), .mem2reg(mem2reg), .spc2reg(spc2reg), .mem_r(mem_r),
    .mem_w(mem_w), .alu_op(alu_op), .has_funct(has_funct), .jump(jump),
    .pc2imm(pc2imm), .word_op(word_op),
    .reg_w(reg_w), .pc_we(pc_we), .busy(busy), .halted(halted),
    .illegal(illegal), .mem_err(mem_err), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle reset; leaves the bench in the first FETCH cycle.
  task automatic do_reset();
    rst_n   = 1'b0;
    ifu_ack = 1'b0;
    lsu_ack = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Issue one instruction from FETCH; ack_dly = extra MEM cycles before lsu_ack
  // (negative: never ack). Returns once WB or HALT is observed.
  task automatic issue(input logic [31:0] iw, input int ack_dly);
    r_lat = 1; r_lsu = 0; r_regw = 0; r_pcwe = 0; r_we = 1'b0; r_done = 1'b0;
    inst    = iw;
    ifu_ack = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      ifu_ack = 1'b0;
      r_lat++;
      if (lsu_req) begin
        r_lsu++;
        r_we    = r_we | lsu_we;
        lsu_ack = (ack_dly >= 0) && (r_lsu == ack_dly + 1);
      end else begin
        lsu_ack = 1'b0;
      end
      if (reg_w) r_regw++;
      if (pc_we) begin
        r_pcwe++;
        cap_alu_src = alu_src;
        cap_mem2reg = mem2reg;
        cap_alu_op  = alu_op;
        cap_jump    = jump;
      end
      if (pc_we || halted) begin
        r_done = 1'b1;
        break;
      end
    end
    lsu_ack = 1'b0;
    if (!r_done) check("issue_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; ifu_ack = 1'b0; inst = '0; lsu_ack = 1'b0;
    rs1_val = 64'hFFFF_FFFF_FFFF_FFFF; rs2_val = 64'd1;

    // Reset values
    step(); step();
    check("rst_busy", busy, 1);
    check("rst_halted", halted, 0);
    check("rst_instret", instret, 0);
    check("rst_pc_we", pc_we, 0);
    check("rst_lsu_req", lsu_req, 0);
    check("rst_alu_src", alu_src, 0);
    rst_n = 1'b1;
    check("rst_ifu_req", ifu_req, 1);

    // ADDI x1,x0,1
    issue(32'h0010_0093, 0);
    check("addi_lat", r_lat, 4);
    check("addi_regw", r_regw, 1);
    check("addi_pcwe", r_pcwe, 1);
    check("addi_alu_src", cap_alu_src, 1);
    check("addi_alu_op", cap_alu_op, 0);
    check("addi_instret", instret, 1);
    step();
    check("addi_back_fetch", ifu_req, 1);
    check("addi_fetch_regw", reg_w, 0);
    check("addi_fetch_dec0", alu_src, 0);

    // BLT -1 < 1 signed -> taken
    issue(32'h0020_C063, 0);
    check("blt_jump", cap_jump, 1);
    check("blt_regw", r_regw, 0);
    check("blt_pcwe", r_pcwe, 1);
    check("blt_lat", r_lat, 4);
    step();
    // BLTU: all-ones unsigned is not < 1
    issue(32'h0020_E063, 0);
    check("bltu_jump", cap_jump, 0);
    check("bltu_regw", r_regw, 0);
    check("bltu_pcwe", r_pcwe, 1);
    step();
    // BNE -> taken
    issue(32'h0020_9063, 0);
    check("bne_jump", cap_jump, 1);
    check("br_instret", instret, 4);
    step();

    // LD with ack on the 4th MEM cycle (exactly at the timeout limit)
    issue(32'h0001_3083, 3);
    check("ld_lsu_cycles", r_lsu, 4);
    check("ld_lsu_we", r_we, 0);
    check("ld_mem2reg", cap_mem2reg, 1);
    check("ld_regw", r_regw, 1);
    check("ld_lat", r_lat, 8);
    check("ld_mem_err", mem_err, 0);
    check("ld_instret", instret, 5);
    step();

    // SD with immediate ack
    issue(32'h0011_3023, 0);
    check("sd_lat", r_lat, 5);
    check("sd_lsu_we", r_we, 1);
    check("sd_regw", r_regw, 0);
    check("sd_instret", instret, 6);
    step();

    // SD never acked -> timeout halt
    issue(32'h0011_3023, -1);
    check("sdto_lsu_cycles", r_lsu, 4);
    check("sdto_pcwe", r_pcwe, 0);
    check("sdto_mem_err", mem_err, 1);
    check("sdto_halted", halted, 1);
    check("sdto_busy", busy, 0);
    check("sdto_instret", instret, 6);
    // HALT absorbs fetch attempts
    ifu_ack = 1'b1;
    step(); step(); step();
    ifu_ack = 1'b0;
    check("halt_ifu_req", ifu_req, 0);
    check("halt_lsu_req", lsu_req, 0);
    check("halt_pc_we", pc_we, 0);
    check("halt_stay", halted, 1);

    // Unlisted opcode
    do_reset();
    check("rst2_ifu_req", ifu_req, 1);
    check("rst2_mem_err", mem_err, 0);
    issue(32'h0000_007F, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("ill_illegal", illegal, 1);
    check("ill_halted", halted, 1);
    check("ill_pcwe", r_pcwe, 0);
    check("ill_instret", instret, 0);
`else
    check("nop_illegal", illegal, 0);
    check("nop_pcwe", r_pcwe, 1);
    check("nop_regw", r_regw, 0);
    check("nop_alu_src", cap_alu_src, 0);
    check("nop_instret", instret, 1);
`endif

    // EBREAK halts with no commit
    do_reset();
    issue(32'h0010_0073, 0);
    check("ebreak_halted", halted, 1);
    check("ebreak_pcwe", r_pcwe, 0);
    check("ebreak_regw", r_regw, 0);
    check("ebreak_instret", instret, 0);

    // Reset mid-MEM, after an ADDI to make instret nonzero
    do_reset();
    issue(32'h0010_0093, 0);
    step();
    check("pre_mid_instret", instret, 1);
    inst = 32'h0001_3083; ifu_ack = 1'b1;
    step(); ifu_ack = 1'b0;       // DECODE
    step();                       // EXEC
    step();                       // MEM 1
    check("mid_in_mem", lsu_req, 1);
    step();                       // MEM 2
    rst_n = 1'b0;
    step();
    check("mid_rst_lsu_req", lsu_req, 0);
    check("mid_rst_instret", instret, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_pc_we", pc_we, 0);
    rst_n = 1'b1;
    check("mid_rst_ifu_req", ifu_req, 1);
    // Fresh wait counter: ack on 4th MEM cycle still commits
    issue(32'h0001_3083, 3);
    check("post_ld_regw", r_regw, 1);
    check("post_ld_err", mem_err, 0);
    check("post_ld_instret", instret, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter XLEN, default 64: register-operand width for branch compare.
REQ-002 Parameter MEM_TIMEOUT, default 255: maximum cycles waiting for lsu_ack; minimum 1.
REQ-003 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-004 Ports: clk  in  1  clock, all logic on rising edge; rst_n  in  1  synchronous active-low reset.
REQ-005 Fetch ports: ifu_req  out  1  fetch request; ifu_ack  in  1  instruction valid; inst  in  32  instruction word.
REQ-006 Operand ports: rs1_val  in  XLEN  and rs2_val  in  XLEN, register-file read data for the latched instruction.
REQ-007 Memory ports: lsu_req  out  1  memory request; lsu_we  out  1  store when high; lsu_ack  in  1  access done.
REQ-008 Decode outputs (all out): alu_src 1, mem2reg 1, spc2reg 1, mem_r 1, mem_w 1, alu_op 2, has_funct 2, jump 1, pc2imm 1, word_op 1 (opcode 0111011 or 0011011).
REQ-009 Commit outputs: reg_w  out  1  register write strobe; pc_we  out  1  PC update strobe.
REQ-010 Status outputs: busy  out  1  (not in HALT); halted  out  1; illegal  out  1; mem_err  out  1; instret  out  CNT_W.

Function
REQ-011 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-012 FETCH: ifu_req=1; on ifu_ack=1, latch inst into IR and go to DECODE. ifu_ack is ignored outside FETCH.
REQ-013 DECODE (1 cycle): register the decode fields from IR[6:0]. Encoding per opcode: load 0000011, store 0100011, OP-IMM 0010011, OP 0110011, AUIPC 0010111, JAL 1101111, JALR 1100111, OP-32 0111011, OP-IMM-32 0011011, BRANCH 1100011, SYSTEM 1110011. The codes match the single-cycle decoder's encodings.
REQ-014 EXEC (1 cycle): sample rs1_val/rs2_val. For BRANCH, set jump from IR[14:12]: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; other codes give 0. Compares span full XLEN.
REQ-015 EXEC exit: load/store go to MEM; ebreak (IR=0x00100073) goes to HALT; all others go to WB.
REQ-016 MEM: lsu_req=1 and lsu_we=mem_w, held until lsu_ack=1, then go to WB.
REQ-017 MEM timeout: wait counter clears on MEM entry; if MEM_TIMEOUT cycles elapse without lsu_ack, set mem_err=1 and go to HALT with no commit.
REQ-018 WB (1 cycle): reg_w=1 if the opcode writes rd; pc_we=1 always; instret increments by 1 (wraps at 2^CNT_W-1 to 0); then go to FETCH.
REQ-019 reg_w and pc_we are single-cycle pulses, asserted only in WB.
REQ-020 Decode outputs hold from DECODE exit until WB exit and are 0 in FETCH and HALT.
REQ-021 Latency, ack in the first request cycle: non-memory instruction 4 cycles (FETCH to WB inclusive); load/store 5 cycles.
REQ-022 HALT is absorbing until reset: halted=1, busy=0, all requests and strobes 0.
REQ-023 If lsu_ack arrives on the cycle the counter reaches MEM_TIMEOUT, the ack wins: go to WB, mem_err stays 0.

Reset
REQ-024 While rst_n=0 at a clock edge: state=FETCH; IR=0; counters=0; all decode, commit and status outputs 0 except busy=1.
REQ-025 Reset in any state, including mid-MEM, aborts the instruction with no commit; ifu_req=1 on the first cycle after release.

Configuration
REQ-026 Macro CTRL_ILLEGAL_TRAP_EN.
REQ-027 When defined, an unlisted opcode in DECODE sets illegal=1 and the FSM goes to HALT at EXEC exit.
REQ-028 When undefined, an unlisted opcode decodes as NOP: all decode fields 0, reg_w=0, pc_we=1 in WB, instret increments; illegal is tied to 0.

Verification
REQ-029 ADDI (0x00100093) with ifu_ack in the first FETCH cycle: reg_w and pc_we pulse in cycle 4; instret=1; alu_src=1; alu_op=00.
REQ-030 BLT with rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1: jump=1. BLTU with the same operands: jump=0. In both cases reg_w=0 and pc_we=1.
REQ-031 LD with lsu_ack delayed 3 cycles: lsu_req high 4 cycles, lsu_we=0, mem2reg=1, reg_w pulses once.
REQ-032 SD with no lsu_ack and MEM_TIMEOUT=4: mem_err=1, halted=1, instret unchanged. Also, ack exactly at the limit gives a normal commit.
REQ-033 Opcode 0x0000007F: with CTRL_ILLEGAL_TRAP_EN, illegal=1 and halted=1; without it, a NOP commit and instret+1.
REQ-034 Ebreak gives halted=1 with no commit. rst_n=0 for one cycle mid-MEM returns to FETCH with lsu_req=0 and all counters 0.
